// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its serial deserializer.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_PAUSE = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_e;

endpackage : usr_pkg

// File: rtl/deser_shift_stage.sv
// WIDTH-bit shift register for the deserializer; clear takes priority over shift.
module deser_shift_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             dir_left_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] sr_o,
    output logic [WIDTH-1:0] shifted_c
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Shifted value is exposed so the completion edge can capture the final bit.
    always_comb begin
        if (dir_left_i) begin
            shifted_c = {sr_q[WIDTH-2:0], sin_i};
        end else begin
            shifted_c = {sin_i, sr_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        sr_d = sr_q;
        if (clr_i) begin
            sr_d = '0;
        end else if (en_i) begin
            sr_d = shifted_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr_o = sr_q;

endmodule : deser_shift_stage

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: frames WIDTH bits, presents words with valid/ready and sticky overrun.
module shift_deserializer
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode_i,
    input  logic             sin_i,
    input  logic             svalid_i,
    output logic [WIDTH-1:0] dataout_o,
    output logic             dvalid_o,
    input  logic             dready_i,
    output logic             busy_o,
    output logic             overrun_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    deser_state_e     state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_left_q, dir_left_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;

    logic             consume;
    logic             abort;
    logic             sr_clr;
    logic             sr_en;
    logic             dir_left_eff;
    logic [WIDTH-1:0] sr_val;
    logic [WIDTH-1:0] shifted;

    assign consume = svalid_i && ((mode_i == MODE_SHR) || (mode_i == MODE_SHL));
    assign abort   = (mode_i == MODE_HOLD);

    // The first bit of a frame uses the live MODE; later bits use the latched direction.
    assign dir_left_eff = (state_q == IDLE) ? (mode_i == MODE_SHL) : dir_left_q;

    deser_shift_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (sr_clr),
        .en_i       (sr_en),
        .dir_left_i (dir_left_eff),
        .sin_i      (sin_i),
        .sr_o       (sr_val),
        .shifted_c  (shifted)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_left_d = dir_left_q;
        dout_d     = dout_q;
        dvalid_d   = dvalid_q;
        ovr_d      = ovr_q;
        sr_clr     = 1'b0;
        sr_en      = 1'b0;

        if (abort) begin
            state_d    = IDLE;
            cnt_d      = '0;
            dir_left_d = 1'b0;
            dout_d     = '0;
            dvalid_d   = 1'b0;
            ovr_d      = 1'b0;
            sr_clr     = 1'b1;
        end else begin
            if (dvalid_q && dready_i) begin
                dvalid_d = 1'b0;
            end
            if (consume) begin
                sr_en = 1'b1;
                if (state_q == IDLE) begin
                    dir_left_d = (mode_i == MODE_SHL);
                    state_d    = SHIFT;
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Completion edge: capture the word including this bit, restart the frame.
                    dout_d   = shifted;
                    dvalid_d = 1'b1;
                    if (dvalid_q && !dready_i) begin
                        ovr_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                    sr_clr  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dir_left_q <= 1'b0;
            dout_q     <= '0;
            dvalid_q   <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_left_q <= dir_left_d;
            dout_q     <= dout_d;
            dvalid_q   <= dvalid_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign dataout_o = dout_q;
    assign dvalid_o  = dvalid_q;
    assign busy_o    = busy_q;
    assign overrun_o = ovr_q;

    logic unused_sr;
    assign unused_sr = ^sr_val;

endmodule : shift_deserializer

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer at WIDTH=4 with hand-computed expectations.
module tb_shift_deserializer;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [1:0]       mode_i;
    logic             sin_i;
    logic             svalid_i;
    logic [WIDTH-1:0] dataout_o;
    logic             dvalid_o;
    logic             dready_i;
    logic             busy_o;
    logic             overrun_o;

    int total;
    int bad;

    shift_deserializer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_i    (mode_i),
        .sin_i     (sin_i),
        .svalid_i  (svalid_i),
        .dataout_o (dataout_o),
        .dvalid_o  (dvalid_o),
        .dready_i  (dready_i),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock one rising edge, then settle before sampling.
    task automatic tick(input logic [1:0] m, input logic s, input logic sv, input logic rdy);
        mode_i   = m;
        sin_i    = s;
        svalid_i = sv;
        dready_i = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] d, input logic v,
                              input logic b, input logic o);
        check({tag, ".dataout"}, 32'(dataout_o), 32'(d));
        check({tag, ".dvalid"},  32'(dvalid_o),  32'(v));
        check({tag, ".busy"},    32'(busy_o),    32'(b));
        check({tag, ".overrun"}, 32'(overrun_o), 32'(o));
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        mode_i   = 2'b00;
        sin_i    = 1'b0;
        svalid_i = 1'b0;
        dready_i = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(2'b11, 1'b0, 1'b0, 1'b0);

        // LSB-first 1,1,0,0
        tick(2'b01, 1'b1, 1'b1, 1'b0);
        check("lsb.sr1", 32'(dut.u_stage.sr_o), 32'h8);
        check("lsb.busy1", 32'(busy_o), 32'h1);
        tick(2'b01, 1'b1, 1'b1, 1'b0);
        check("lsb.sr2", 32'(dut.u_stage.sr_o), 32'hC);
        tick(2'b01, 1'b0, 1'b1, 1'b0);
        check("lsb.sr3", 32'(dut.u_stage.sr_o), 32'h6);
        check("lsb.dvalid3", 32'(dvalid_o), 32'h0);
        tick(2'b01, 1'b0, 1'b1, 1'b0);
        check_outs("lsb.done", 4'b0011, 1'b1, 1'b0, 1'b0);
        check("lsb.sr_clr", 32'(dut.u_stage.sr_o), 32'h0);
        tick(2'b11, 1'b0, 1'b0, 1'b1);
        check_outs("lsb.accept", 4'b0011, 1'b0, 1'b0, 1'b0);

        // MSB-first 0,1,<gap of 3>,1,1
        tick(2'b10, 1'b0, 1'b1, 1'b0);
        tick(2'b10, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(2'b10, 1'b1, 1'b0, 1'b0);
            check("msb.gap_busy", 32'(busy_o), 32'h1);
            check("msb.gap_dvalid", 32'(dvalid_o), 32'h0);
        end
        tick(2'b10, 1'b1, 1'b1, 1'b0);
        tick(2'b10, 1'b1, 1'b1, 1'b0);
        check_outs("msb.done", 4'b0111, 1'b1, 1'b0, 1'b0);
        tick(2'b11, 1'b0, 1'b0, 1'b1);

        // Overrun: 1,0,1,0 then 0,1,0,1 back to back, never accepted
        tick(2'b01, 1'b1, 1'b1, 1'b0);
        tick(2'b01, 1'b0, 1'b1, 1'b0);
        tick(2'b01, 1'b1, 1'b1, 1'b0);
        tick(2'b01, 1'b0, 1'b1, 1'b0);
        check_outs("ovr.f1", 4'b0101, 1'b1, 1'b0, 1'b0);
        tick(2'b01, 1'b0, 1'b1, 1'b0);
        check("ovr.hold_data", 32'(dataout_o), 32'h5);
        tick(2'b01, 1'b1, 1'b1, 1'b0);
        tick(2'b01, 1'b0, 1'b1, 1'b0);
        tick(2'b01, 1'b1, 1'b1, 1'b0);
        check_outs("ovr.f2", 4'b1010, 1'b1, 1'b0, 1'b1);
        tick(2'b11, 1'b0, 1'b0, 1'b0);
        check("ovr.sticky", 32'(overrun_o), 32'h1);
        tick(2'b00, 1'b0, 1'b0, 1'b0);
        check_outs("ovr.clear", 4'h0, 1'b0, 1'b0, 1'b0);

        // Completion and accept on the same edge
        for (int i = 0; i < 4; i++) tick(2'b01, 1'b1, 1'b1, 1'b0);
        check_outs("sim.f1", 4'b1111, 1'b1, 1'b0, 1'b0);
        tick(2'b01, 1'b1, 1'b1, 1'b0);
        tick(2'b01, 1'b0, 1'b1, 1'b0);
        tick(2'b01, 1'b0, 1'b1, 1'b0);
        tick(2'b01, 1'b0, 1'b1, 1'b1);
        check_outs("sim.f2", 4'b0001, 1'b1, 1'b0, 1'b0);
        tick(2'b11, 1'b0, 1'b0, 1'b1);
        check("sim.accept", 32'(dvalid_o), 32'h0);

        // Asynchronous reset mid-frame
        tick(2'b10, 1'b1, 1'b1, 1'b0);
        tick(2'b10, 1'b1, 1'b1, 1'b0);
        check("rst.busy_before", 32'(busy_o), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_outs("rst.mid", 4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2'b10, 1'b1, 1'b1, 1'b0);
        tick(2'b10, 1'b0, 1'b1, 1'b0);
        tick(2'b10, 1'b1, 1'b1, 1'b0);
        tick(2'b10, 1'b0, 1'b1, 1'b0);
        check_outs("rst.frame", 4'b1010, 1'b1, 1'b0, 1'b0);
        tick(2'b11, 1'b0, 1'b0, 1'b1);

        // Abort mid-frame with MODE=00
        tick(2'b10, 1'b0, 1'b1, 1'b0);
        tick(2'b10, 1'b1, 1'b1, 1'b0);
        tick(2'b00, 1'b1, 1'b1, 1'b0);
        check_outs("abort.mid", 4'h0, 1'b0, 1'b0, 1'b0);
        tick(2'b10, 1'b1, 1'b1, 1'b0);
        tick(2'b10, 1'b0, 1'b1, 1'b0);
        tick(2'b10, 1'b1, 1'b1, 1'b0);
        tick(2'b10, 1'b0, 1'b1, 1'b0);
        check_outs("abort.frame", 4'b1010, 1'b1, 1'b0, 1'b0);
        tick(2'b11, 1'b0, 1'b0, 1'b1);

        // Direction latched at frame start; pause with SVALID=1 consumes nothing
        tick(2'b01, 1'b1, 1'b1, 1'b0);
        tick(2'b11, 1'b1, 1'b1, 1'b0);
        check("dir.pause_busy", 32'(busy_o), 32'h1);
        tick(2'b10, 1'b0, 1'b1, 1'b0);
        tick(2'b10, 1'b1, 1'b1, 1'b0);
        check("dir.not_done", 32'(dvalid_o), 32'h0);
        tick(2'b10, 1'b1, 1'b1, 1'b0);
        check_outs("dir.done", 4'b1101, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_shift_deserializer
